// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40UP 16K x 16 single-port SPRAM primitive.
// Writes honour the per-nibble mask; DATAOUT is registered and only updates on reads.
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem_q [16384];
  logic        active_s;

  assign active_s = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;

  // Masked nibble writes
  always_ff @(posedge CLOCK) begin
    if (active_s && WREN) begin
      for (int n = 0; n < 4; n++) begin
        if (MASKWREN[n]) begin
          mem_q[ADDRESS][n*4 +: 4] <= DATAIN[n*4 +: 4];
        end
      end
    end
  end

  // Registered read port
  always_ff @(posedge CLOCK) begin
    if (active_s && !WREN) begin
      DATAOUT <= mem_q[ADDRESS];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SPRAM between a buffered write stream and several round-robin read channels.
// Writes and reads alternate when both are pending; a read returns its word on a one-cycle strobe.
module sram_arbiter #(
  parameter int ADDRESS_BUS_WIDTH = 14,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int READ_PORTS        = 2,
  parameter int WFIFO_DEPTH       = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [ADDRESS_BUS_WIDTH-1:0]            write_address,
  input  logic [DATA_BUS_WIDTH-1:0]               write_data,
  input  logic                                    write_strobe,
  output logic                                    write_full,
  output logic                                    write_overflow,
  input  logic [READ_PORTS*ADDRESS_BUS_WIDTH-1:0] read_address,
  input  logic [READ_PORTS-1:0]                   read_request,
  output logic [READ_PORTS-1:0]                   read_finished_strobe,
  output logic [DATA_BUS_WIDTH-1:0]               read_data,
  output logic [2:0]                              state
);

  localparam int PTR_W   = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int CH_W    = (READ_PORTS > 1) ? $clog2(READ_PORTS) : 1;
  localparam int ENTRY_W = ADDRESS_BUS_WIDTH + DATA_BUS_WIDTH;

  localparam logic [2:0]       ST_IDLE       = 3'd0;
  localparam logic [2:0]       ST_WRITE      = 3'd1;
  localparam logic [2:0]       ST_READ       = 3'd2;
  localparam logic [2:0]       ST_READ_READY = 3'd3;
  localparam logic [2:0]       ST_WAIT       = 3'd4;
  localparam logic [CNT_W-1:0] DEPTH_C       = CNT_W'(WFIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE       = PTR_W'(1);

  logic [2:0]                   state_q, state_d;
  logic [ENTRY_W-1:0]           fifo_q [WFIFO_DEPTH];
  logic [ENTRY_W-1:0]           head_s;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         full_q, overflow_q, overflow_d;
  logic                         push_s, pop_s, fifo_empty_s;
  logic                         rr_found_s;
  logic [CH_W-1:0]              rr_ch_s;
  int                           dist_s, best_dist_s;
  logic [CH_W-1:0]              last_grant_q, last_grant_d, read_ch_q, read_ch_d;
  logic                         last_was_write_q, last_was_write_d;
  logic                         grant_write_s, grant_read_s;
  logic [ADDRESS_BUS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_BUS_WIDTH-1:0]    ram_wdata_q, ram_wdata_d;
  logic                         ram_wren_q, ram_wren_d;
  logic [DATA_BUS_WIDTH-1:0]    read_data_q, read_data_d;
  logic [READ_PORTS-1:0]        strobe_q, strobe_d;
  logic [13:0]                  spram_addr_s;
  logic [15:0]                  spram_din_s, spram_dout_s;
  logic                         spram_wren_s;

  assign head_s       = fifo_q[rd_ptr_q];
  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
  // A dropped strobe still counts as overflow even when a pop frees a slot this cycle.
  assign push_s       = write_strobe & ~full_q & ~rst;
  assign pop_s        = grant_write_s;

  // FIFO pointer, occupancy and overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (write_strobe & full_q);
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= {write_address, write_data};
    end
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_C);
      overflow_q <= overflow_d;
    end
  end

  // Round-robin pick: smallest distance past the last granted channel
  always_comb begin
    rr_found_s  = 1'b0;
    rr_ch_s     = last_grant_q;
    dist_s      = 0;
    best_dist_s = READ_PORTS;
    for (int i = 0; i < READ_PORTS; i++) begin
      dist_s = (i + READ_PORTS - int'(last_grant_q) - 1) % READ_PORTS;
      if (read_request[i] && (dist_s < best_dist_s)) begin
        rr_found_s  = 1'b1;
        best_dist_s = dist_s;
        rr_ch_s     = CH_W'(i);
      end else begin
        rr_found_s  = rr_found_s;
      end
    end
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant decision and next state
  always_comb begin
    grant_write_s = (state_q == ST_IDLE) && !fifo_empty_s && (!last_was_write_q || !rr_found_s);
    grant_read_s  = (state_q == ST_IDLE) && !grant_write_s && rr_found_s;
    case (state_q)
      ST_IDLE: begin
        if (grant_write_s) begin
          state_d = ST_WRITE;
        end else if (grant_read_s) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE:      state_d = ST_IDLE;
      ST_READ:       state_d = ST_READ_READY;
      ST_READ_READY: state_d = ST_WAIT;
      ST_WAIT:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Datapath loads driven by the current state and grant
  always_comb begin
    ram_addr_d       = ram_addr_q;
    ram_wdata_d      = ram_wdata_q;
    ram_wren_d       = 1'b0;
    read_ch_d        = read_ch_q;
    last_grant_d     = last_grant_q;
    last_was_write_d = last_was_write_q;
    read_data_d      = read_data_q;
    strobe_d         = {READ_PORTS{1'b0}};
    if (grant_write_s) begin
      ram_addr_d       = head_s[ENTRY_W-1 -: ADDRESS_BUS_WIDTH];
      ram_wdata_d      = head_s[DATA_BUS_WIDTH-1:0];
      ram_wren_d       = 1'b1;
      last_was_write_d = 1'b1;
    end else if (grant_read_s) begin
      ram_addr_d       = read_address[int'(rr_ch_s)*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
      read_ch_d        = rr_ch_s;
      last_grant_d     = rr_ch_s;
      last_was_write_d = 1'b0;
    end else begin
      ram_wren_d = 1'b0;
    end
    if (state_q == ST_READ_READY) begin
      read_data_d = DATA_BUS_WIDTH'(spram_dout_s);
      strobe_d    = READ_PORTS'(1'b1) << read_ch_q;
    end else begin
      strobe_d = {READ_PORTS{1'b0}};
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_q       <= {ADDRESS_BUS_WIDTH{1'b0}};
      ram_wdata_q      <= {DATA_BUS_WIDTH{1'b0}};
      ram_wren_q       <= 1'b0;
      read_ch_q        <= {CH_W{1'b0}};
      last_grant_q     <= CH_W'(READ_PORTS - 1);
      last_was_write_q <= 1'b0;
      read_data_q      <= {DATA_BUS_WIDTH{1'b0}};
      strobe_q         <= {READ_PORTS{1'b0}};
    end else begin
      ram_addr_q       <= ram_addr_d;
      ram_wdata_q      <= ram_wdata_d;
      ram_wren_q       <= ram_wren_d;
      read_ch_q        <= read_ch_d;
      last_grant_q     <= last_grant_d;
      last_was_write_q <= last_was_write_d;
      read_data_q      <= read_data_d;
      strobe_q         <= strobe_d;
    end
  end

  // Reset at the WRITE edge must not let the pending write land in the RAM.
  assign spram_wren_s = ram_wren_q & ~rst;
  assign spram_addr_s = 14'(ram_addr_q);
  assign spram_din_s  = 16'(ram_wdata_q);

  SB_SPRAM256KA u_spram (
    .ADDRESS    (spram_addr_s),
    .DATAIN     (spram_din_s),
    .MASKWREN   (4'b1111),
    .WREN       (spram_wren_s),
    .CHIPSELECT (1'b1),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (spram_dout_s)
  );

  assign write_full           = full_q;
  assign write_overflow       = overflow_q;
  assign read_finished_strobe = strobe_q;
  assign read_data            = read_data_q;
  assign state                = state_q;

endmodule
